line_memory_model: RTL and testbench



---
 rtl/mem_model_pkg.sv | 9 +
 rtl/line_memory_model_line_store.sv | 36 +++
 rtl/line_memory_model.sv | 117 +++++++++++
 tb/tb_line_memory_model.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared types and constants for the line-granular memory model.
package mem_model_pkg;
  localparam int LINE_BITS   = 512;
  localparam int OFFSET_BITS = 6;
  localparam logic [31:0] FILL_WORD = 32'hDEADBEEF;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/line_memory_model_line_store.sv
// Line array with per-line valid bits; never-written lines read back as the fill pattern.
module line_store #(
  parameter int          LINE_BITS   = 512,
  parameter int          DEPTH_LINES = 1024,
  parameter int          IDX_W       = 10,
  parameter logic [31:0] FILL_WORD   = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [LINE_BITS-1:0] rd_data
);
  localparam logic [LINE_BITS-1:0] FILL_LINE = {(LINE_BITS/32){FILL_WORD}};

  logic [LINE_BITS-1:0]   mem [DEPTH_LINES];
  logic [DEPTH_LINES-1:0] valid;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Contents survive reset; only the valid bits decide what a read returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) valid[wr_idx] <= 1'b1;
      if (rd_en) rd_data <= valid[rd_idx] ? mem[rd_idx] : FILL_LINE;
    end
  end
endmodule

// File: rtl/line_memory_model.sv
// Cycle-accurate line store behind the cache controller: one transaction at a time,
// completion signalled by a single mem_ready pulse after a fixed per-op latency.
module line_memory_model #(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          LINE_BITS     = mem_model_pkg::LINE_BITS,
  parameter int          DEPTH_LINES   = 1024,
  parameter int          READ_LATENCY  = 4,
  parameter int          WRITE_LATENCY = 2,
  parameter logic [31:0] FILL_WORD     = mem_model_pkg::FILL_WORD
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  input  logic [LINE_BITS-1:0]  mem_write_data,
  output logic [LINE_BITS-1:0]  mem_read_data,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  protocol_error,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);
  import mem_model_pkg::*;

  localparam int IDX_W   = $clog2(DEPTH_LINES);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  state_e               state;
  state_e               next_state;
  logic [CNT_W-1:0]     cnt;
  logic                 op_wr;
  logic [IDX_W-1:0]     idx_q;
  logic [LINE_BITS-1:0] wdata_q;

  logic [IDX_W-1:0]     in_idx;
  logic                 acc_wr, acc_rd, accept, acc_lat1;
  logic                 fin, fin_wr;
  logic [IDX_W-1:0]     fin_idx;
  logic [LINE_BITS-1:0] fin_data;
  logic                 unused_addr;

  assign in_idx      = mem_address[OFFSET_BITS +: IDX_W];
  assign unused_addr = ^{mem_address[OFFSET_BITS-1:0], mem_address[ADDR_WIDTH-1:OFFSET_BITS+IDX_W]};

  // A latency-1 accept completes on the same edge, so completion muxes between
  // the live request (IDLE) and the captured one (BUSY).
  always_comb begin
    acc_wr     = (state == IDLE) && mem_write_enable;
    acc_rd     = (state == IDLE) && !mem_write_enable && mem_read_enable;
    accept     = acc_wr || acc_rd;
    acc_lat1   = acc_wr ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);
    fin        = reset_n && (((state == BUSY) && (cnt == '0)) || (accept && acc_lat1));
    fin_wr     = (state == BUSY) ? op_wr   : acc_wr;
    fin_idx    = (state == BUSY) ? idx_q   : in_idx;
    fin_data   = (state == BUSY) ? wdata_q : mem_write_data;
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = acc_lat1 ? DONE : BUSY;
      BUSY:    if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      op_wr          <= 1'b0;
      mem_ready      <= 1'b0;
      busy           <= 1'b0;
      protocol_error <= 1'b0;
      rd_count       <= '0;
      wr_count       <= '0;
    end else begin
      state     <= next_state;
      mem_ready <= fin;
      busy      <= (next_state != IDLE);
      if (accept) begin
        op_wr <= acc_wr;
        cnt   <= acc_wr ? WR_LOAD : RD_LOAD;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (acc_wr && mem_read_enable) protocol_error <= 1'b1;
      if (fin && fin_wr)  wr_count <= wr_count + 16'd1;
      if (fin && !fin_wr) rd_count <= rd_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= in_idx;
      wdata_q <= mem_write_data;
    end
  end

  line_store #(
    .LINE_BITS  (LINE_BITS),
    .DEPTH_LINES(DEPTH_LINES),
    .IDX_W      (IDX_W),
    .FILL_WORD  (FILL_WORD)
  ) u_store (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (fin && fin_wr),
    .wr_idx (fin_idx),
    .wr_data(fin_data),
    .rd_en  (fin && !fin_wr),
    .rd_idx (fin_idx),
    .rd_data(mem_read_data)
  );
endmodule

// File: tb/tb_line_memory_model.sv
// Directed bench for line_memory_model with default parameters (read 4, write 2 cycles).
module tb_line_memory_model;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  mem_address;
  logic         mem_read_enable;
  logic         mem_write_enable;
  logic [511:0] mem_write_data;
  logic [511:0] mem_read_data;
  logic         mem_ready;
  logic         busy;
  logic         protocol_error;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [511:0] FILL  = {16{32'hDEADBEEF}};
  localparam logic [511:0] PAT_A = {16{32'h87654321}};
  localparam logic [511:0] PAT_B = {16{32'hAAAABBBB}};
  localparam logic [511:0] PAT_C = {16{32'h11223344}};
  localparam logic [511:0] PAT_D = {16{32'hCAFEF00D}};

  line_memory_model dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_address     (mem_address),
    .mem_read_enable (mem_read_enable),
    .mem_write_enable(mem_write_enable),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data),
    .mem_ready       (mem_ready),
    .busy            (busy),
    .protocol_error  (protocol_error),
    .rd_count        (rd_count),
    .wr_count        (wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, mem_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_perr"}, protocol_error, 0);
    chk({tag, "_rdcnt"}, rd_count, 0);
    chk({tag, "_wrcnt"}, wr_count, 0);
    chk({tag, "_rdata"}, mem_read_data, 0);
  endtask

  // Issue one request, scramble the inputs after acceptance, and check the timing.
  task automatic run_txn(input logic we, input logic re, input logic [31:0] addr,
                         input logic [511:0] wd, input int lat, input string tag);
    mem_write_enable = we;
    mem_read_enable  = re;
    mem_address      = addr;
    mem_write_data   = wd;
    tick();
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_address      = addr ^ 32'hFFFF_FFC0;
    mem_write_data   = ~wd;
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_busy_pending"}, busy, 1);
      chk({tag, "_ready_early"}, mem_ready, 0);
      tick();
    end
    chk({tag, "_ready_pulse"}, mem_ready, 1);
    chk({tag, "_busy_done"}, busy, 1);
    tick();
    chk({tag, "_ready_after"}, mem_ready, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    reset_n          = 1'b0;
    mem_address      = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    repeat (3) tick();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Cold read of a never-written line
    run_txn(1'b0, 1'b1, 32'h0000_1000, '0, 4, "cold_rd");
    chk("cold_rd_data", mem_read_data, FILL);
    chk("cold_rd_rdcnt", rd_count, 1);
    chk("cold_rd_wrcnt", wr_count, 0);

    // Write then read the same line through a different offset
    run_txn(1'b1, 1'b0, 32'h0000_2000, PAT_A, 2, "wr_a");
    chk("wr_a_wrcnt", wr_count, 1);
    chk("wr_a_rdata_held", mem_read_data, FILL);
    run_txn(1'b0, 1'b1, 32'h0000_203C, '0, 4, "rd_a");
    chk("rd_a_data", mem_read_data, PAT_A);
    chk("rd_a_rdcnt", rd_count, 2);

    // Index wrap: 0x10040 aliases 0x40 with 1024 lines
    run_txn(1'b1, 1'b0, 32'h0000_0040, PAT_B, 2, "wr_b");
    run_txn(1'b0, 1'b1, 32'h0001_0040, '0, 4, "rd_wrap");
    chk("rd_wrap_data", mem_read_data, PAT_B);
    chk("rd_wrap_wrcnt", wr_count, 2);
    chk("rd_wrap_rdcnt", rd_count, 3);

    // Both enables: write wins, error sticks
    run_txn(1'b1, 1'b1, 32'h0000_3000, PAT_C, 2, "both");
    chk("both_perr", protocol_error, 1);
    chk("both_wrcnt", wr_count, 3);
    chk("both_rdcnt", rd_count, 3);
    chk("both_rdata_held", mem_read_data, PAT_B);
    run_txn(1'b0, 1'b1, 32'h0000_3000, '0, 4, "rd_c");
    chk("rd_c_data", mem_read_data, PAT_C);
    chk("rd_c_perr_sticky", protocol_error, 1);

    // Input churn during BUSY, then a held read_enable retriggers after DONE
    mem_read_enable = 1'b1;
    mem_address     = 32'h0000_2000;
    tick();
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b1;
    mem_address      = 32'h0000_0040;
    mem_write_data   = '0;
    tick();
    chk("churn_busy", busy, 1);
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b1;
    mem_address      = 32'h0000_1000;
    tick();
    tick();
    chk("churn_ready_early", mem_ready, 0);
    tick();
    chk("churn_ready", mem_ready, 1);
    chk("churn_data", mem_read_data, PAT_A);
    chk("churn_rdcnt", rd_count, 5);
    chk("churn_wrcnt", wr_count, 3);
    tick();
    chk("churn_ready_once", mem_ready, 0);
    chk("churn_idle", busy, 0);
    tick();
    chk("held_rd_accept", busy, 1);
    mem_read_enable = 1'b0;
    repeat (3) tick();
    chk("held_rd_ready_early", mem_ready, 0);
    tick();
    chk("held_rd_ready", mem_ready, 1);
    chk("held_rd_data", mem_read_data, FILL);
    chk("held_rd_rdcnt", rd_count, 6);
    tick();
    chk("held_rd_ready_once", mem_ready, 0);
    chk("held_rd_wrcnt", wr_count, 3);

    // Reset in the middle of a write aborts it
    mem_write_enable = 1'b1;
    mem_address      = 32'h0000_4000;
    mem_write_data   = PAT_D;
    tick();
    mem_write_enable = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_ready", mem_ready, 0);
      chk("abort_wrcnt", wr_count, 0);
    end
    reset_n = 1'b1;
    tick();
    run_txn(1'b0, 1'b1, 32'h0000_4000, '0, 4, "post_abort_rd");
    chk("post_abort_data", mem_read_data, FILL);
    chk("post_abort_wrcnt", wr_count, 0);
    chk("post_abort_rdcnt", rd_count, 1);
    chk("post_abort_perr", protocol_error, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
